uart_rx: RTL and testbench

UART receiver, companion to the existing uart_tx. It is placed directly behind the rx pin in the echo path. It oversamples the line with the system clock, locates the centre of each bit, and reassembles data, optional parity and stop bits. Each frame is delivered as a one-cycle valid pulse with error flags. It takes the same runtime config bus as uart_tx, so both directions share one baud/format setting.

---
 rtl/uart_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversamples uart_rxpin, centres on each bit and reassembles data/parity/stop.
// Optional macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote of rxs at counter==2,1,0 for every sample.

`ifndef UART_CONFIG_WIDTH_DELAYFRAMES
`define UART_CONFIG_WIDTH_DELAYFRAMES 16
`endif
`ifndef UART_CONFIG_WIDTH_DATABITS
`define UART_CONFIG_WIDTH_DATABITS 8
`endif
`ifndef UART_PARITY_ODD
`define UART_PARITY_ODD 2'd1
`endif
`ifndef UART_PARITY_EVEN
`define UART_PARITY_EVEN 2'd2
`endif

module uart_rx #(
    parameter int unsigned COUNTER_WIDTH = `UART_CONFIG_WIDTH_DELAYFRAMES,
    parameter int unsigned DATA_WIDTH    = `UART_CONFIG_WIDTH_DATABITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     uart_rxpin,
    output logic [DATA_WIDTH-1:0]    dataout,
    output logic                     rx_valid,
    output logic                     parity_error,
    output logic                     frame_error,
    output logic                     rx_busy,
    input  logic [COUNTER_WIDTH-1:0] UART_CONFIG_DELAY_FRAMES,
    input  logic [4:0]               UART_CONFIG_DATABITS,
    input  logic [1:0]               UART_CONFIG_PARITY,
    input  logic [1:0]               UART_CONFIG_STOPBITS
);

    localparam logic [4:0] DATA_BITS_MAX = 5'(DATA_WIDTH);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_e;

    state_e                   state_q, state_d;
    logic [1:0]               sync_q, sync_d;
    logic                     rxs_prev_q, rxs_prev_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [4:0]               idx_q, idx_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic                     par_acc_q, par_acc_d;
    logic                     pe_q, pe_d;
    logic                     fe_acc_q, fe_acc_d;
    logic                     stop2_q, stop2_d;
    logic [DATA_WIDTH-1:0]    dataout_q, dataout_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     parity_error_q, parity_error_d;
    logic                     frame_error_q, frame_error_d;
    logic                     rx_busy_q, rx_busy_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0]               vote_q, vote_d;
`endif

    logic       rxs;
    logic       tick;
    logic       sample;
    logic       par_en;
    logic       par_odd;
    logic       two_stop;
    logic       fe_now;
    logic [4:0] last_idx;

    assign rxs      = sync_q[1];
    assign tick     = (cnt_q == COUNTER_WIDTH'(0));
    assign par_odd  = (UART_CONFIG_PARITY == `UART_PARITY_ODD);
    assign par_en   = par_odd || (UART_CONFIG_PARITY == `UART_PARITY_EVEN);
    assign two_stop = (UART_CONFIG_STOPBITS == 2'd2);
    assign fe_now   = fe_acc_q | ~sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
    assign sample = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs) | (vote_q[0] & rxs);
`else
    assign sample = rxs;
`endif

    // Index of the final data bit, with DATABITS clamped into 1..DATA_WIDTH
    always_comb begin
        if (UART_CONFIG_DATABITS > DATA_BITS_MAX) begin
            last_idx = DATA_BITS_MAX - 5'd1;
        end else if (UART_CONFIG_DATABITS == 5'd0) begin
            last_idx = 5'd0;
        end else begin
            last_idx = UART_CONFIG_DATABITS - 5'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        sync_d         = {sync_q[0], uart_rxpin};
        rxs_prev_d     = rxs;
        cnt_d          = tick ? cnt_q : cnt_q - COUNTER_WIDTH'(1);
        idx_d          = idx_q;
        shift_d        = shift_q;
        par_acc_d      = par_acc_q;
        pe_d           = pe_q;
        fe_acc_d       = fe_acc_q;
        stop2_d        = stop2_q;
        dataout_d      = dataout_q;
        rx_valid_d     = 1'b0;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
        vote_d = vote_q;
        if (cnt_q == COUNTER_WIDTH'(2)) vote_d[1] = rxs;
        if (cnt_q == COUNTER_WIDTH'(1)) vote_d[0] = rxs;
`endif

        case (state_q)
            S_IDLE: begin
                // Edge detect also blocks restart while a break holds the line low
                if (rxs_prev_q && !rxs) begin
                    state_d = S_START;
                    cnt_d   = UART_CONFIG_DELAY_FRAMES >> 1;
                end
            end
            S_START: begin
                if (tick) begin
                    cnt_d = UART_CONFIG_DELAY_FRAMES;
                    if (sample) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        idx_d     = 5'd0;
                        shift_d   = '0;
                        par_acc_d = par_odd;
                        pe_d      = 1'b0;
                        fe_acc_d  = 1'b0;
                        stop2_d   = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d     = UART_CONFIG_DELAY_FRAMES;
                    shift_d   = shift_q | (DATA_WIDTH'(sample) << idx_q);
                    par_acc_d = par_acc_q ^ sample;
                    idx_d     = idx_q + 5'd1;
                    if (idx_q >= last_idx) begin
                        state_d = par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_d   = UART_CONFIG_DELAY_FRAMES;
                    pe_d    = sample ^ par_acc_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d = UART_CONFIG_DELAY_FRAMES;
                    if (two_stop && !stop2_q) begin
                        stop2_d  = 1'b1;
                        fe_acc_d = fe_now;
                    end else begin
                        state_d        = S_IDLE;
                        rx_valid_d     = 1'b1;
                        dataout_d      = shift_q;
                        parity_error_d = pe_q;
                        frame_error_d  = fe_now;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            sync_q         <= 2'b11;
            rxs_prev_q     <= 1'b1;
            cnt_q          <= '0;
            idx_q          <= 5'd0;
            shift_q        <= '0;
            par_acc_q      <= 1'b0;
            pe_q           <= 1'b0;
            fe_acc_q       <= 1'b0;
            stop2_q        <= 1'b0;
            dataout_q      <= '0;
            rx_valid_q     <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            rx_busy_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote_q         <= 2'b11;
`endif
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            rxs_prev_q     <= rxs_prev_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shift_q        <= shift_d;
            par_acc_q      <= par_acc_d;
            pe_q           <= pe_d;
            fe_acc_q       <= fe_acc_d;
            stop2_q        <= stop2_d;
            dataout_q      <= dataout_d;
            rx_valid_q     <= rx_valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
            rx_busy_q      <= rx_busy_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote_q         <= vote_d;
`endif
        end
    end

    assign dataout      = dataout_q;
    assign rx_valid     = rx_valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames plus glitch, break,
// back-to-back and mid-frame reset sequences.

`ifndef UART_CONFIG_WIDTH_DELAYFRAMES
`define UART_CONFIG_WIDTH_DELAYFRAMES 16
`endif
`ifndef UART_CONFIG_WIDTH_DATABITS
`define UART_CONFIG_WIDTH_DATABITS 8
`endif

module tb_uart_rx;

    localparam int unsigned CW = `UART_CONFIG_WIDTH_DELAYFRAMES;
    localparam int unsigned DW = `UART_CONFIG_WIDTH_DATABITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_rxpin = 1'b1;
    logic [DW-1:0] dataout;
    logic          rx_valid;
    logic          parity_error;
    logic          frame_error;
    logic          rx_busy;
    logic [CW-1:0] cfg_df = CW'(9);
    logic [4:0]    cfg_db = 5'd8;
    logic [1:0]    cfg_par = 2'd0;
    logic [1:0]    cfg_stp = 2'd0;

    uart_rx dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .uart_rxpin               (uart_rxpin),
        .dataout                  (dataout),
        .rx_valid                 (rx_valid),
        .parity_error             (parity_error),
        .frame_error              (frame_error),
        .rx_busy                  (rx_busy),
        .UART_CONFIG_DELAY_FRAMES (cfg_df),
        .UART_CONFIG_DATABITS     (cfg_db),
        .UART_CONFIG_PARITY       (cfg_par),
        .UART_CONFIG_STOPBITS     (cfg_stp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          fe;
        int            c;
        bit            dbl;
    } rx_rec_t;

    typedef struct {
        logic [CW-1:0] df;
        logic [4:0]    db;
        logic [1:0]    par;
        logic [1:0]    stp;
        logic [7:0]    d;
        bit            pflip;
        bit            s1low;
        bit            s2low;
        logic [7:0]    exp_d;
        logic          exp_pe;
        logic          exp_fe;
        int            exp_lat;
    } vec_t;

    rx_rec_t rxq[$];
    rx_rec_t mon_r;
    logic    v_prev = 1'b0;

    // Capture every rx_valid pulse; a pulse lasting more than one cycle is flagged
    always @(negedge clk) begin
        if (rx_valid && !v_prev) begin
            mon_r.data = dataout;
            mon_r.pe   = parity_error;
            mon_r.fe   = frame_error;
            mon_r.c    = cyc;
            mon_r.dbl  = 1'b0;
            rxq.push_back(mon_r);
        end else if (rx_valid && v_prev && rxq.size() > 0) begin
            mon_r     = rxq.pop_back();
            mon_r.dbl = 1'b1;
            rxq.push_back(mon_r);
        end
        v_prev = rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] par,
                              input bit pflip, input logic [1:0] stp, input bit s1low,
                              input bit s2low, input int p, output int start_c);
        logic x;
        logic pb;
        x = 1'b0;
        for (int b = 0; b < nb; b++) x = x ^ d[3'(b)];
        pb = ((par == 2'd1) ? ~x : x) ^ pflip;
        start_c = cyc;
        uart_rxpin = 1'b0;
        hold(p);
        for (int b = 0; b < nb; b++) begin
            uart_rxpin = d[3'(b)];
            hold(p);
        end
        if (par == 2'd1 || par == 2'd2) begin
            uart_rxpin = pb;
            hold(p);
        end
        uart_rxpin = ~s1low;
        if (stp == 2'd1) hold(p + p / 2);
        else             hold(p);
        if (stp == 2'd2) begin
            uart_rxpin = ~s2low;
            hold(p);
        end
        uart_rxpin = 1'b1;
    endtask

    task automatic wait_frame(input string name, output rx_rec_t r);
        int n;
        n = 0;
        while (rxq.size() == 0 && n < 400) begin
            hold(1);
            n++;
        end
        checks++;
        if (rxq.size() == 0) begin
            errors++;
            $display("FAIL %s: actual 0 frames after 400 cycles required 1 frame", name);
            r.data = '0;
            r.pe   = 1'b0;
            r.fe   = 1'b0;
            r.c    = 0;
            r.dbl  = 1'b0;
        end else begin
            hold(1);
            r = rxq.pop_front();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        vec_t    vecs[12];
        rx_rec_t r;
        int      nb;
        int      st;
        int      dummy;
        int      n;

        vecs[0]  = '{CW'(9),  5'd8,  2'd0, 2'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 98};
        vecs[1]  = '{CW'(9),  5'd8,  2'd2, 2'd0, 8'h03, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 108};
        vecs[2]  = '{CW'(9),  5'd8,  2'd2, 2'd0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 108};
        vecs[3]  = '{CW'(9),  5'd8,  2'd1, 2'd2, 8'h7E, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 118};
        vecs[4]  = '{CW'(9),  5'd8,  2'd1, 2'd2, 8'h7E, 1'b0, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 118};
        vecs[5]  = '{CW'(9),  5'd8,  2'd1, 2'd0, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 108};
        vecs[6]  = '{CW'(15), 5'd7,  2'd0, 2'd0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 139};
        vecs[7]  = '{CW'(9),  5'd20, 2'd0, 2'd0, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 98};
        vecs[8]  = '{CW'(9),  5'd8,  2'd0, 2'd3, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 98};
        vecs[9]  = '{CW'(9),  5'd8,  2'd0, 2'd0, 8'hC6, 1'b0, 1'b1, 1'b0, 8'hC6, 1'b0, 1'b1, 98};
        vecs[10] = '{CW'(9),  5'd8,  2'd3, 2'd0, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 98};
        vecs[11] = '{CW'(7),  5'd6,  2'd2, 2'd0, 8'h2D, 1'b0, 1'b0, 1'b0, 8'h2D, 1'b0, 1'b0, 71};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset dataout", 32'(dataout), 32'h0);
        check("reset rx_valid", 32'(rx_valid), 32'h0);
        check("reset parity_error", 32'(parity_error), 32'h0);
        check("reset frame_error", 32'(frame_error), 32'h0);
        check("reset rx_busy", 32'(rx_busy), 32'h0);
        rst_n = 1'b1;
        hold(5);

        for (int i = 0; i < 12; i++) begin
            cfg_df  = vecs[i].df;
            cfg_db  = vecs[i].db;
            cfg_par = vecs[i].par;
            cfg_stp = vecs[i].stp;
            hold(3);
            nb = (vecs[i].db > 5'd8) ? 8 : int'(vecs[i].db);
            send_frame(vecs[i].d, nb, vecs[i].par, vecs[i].pflip, vecs[i].stp,
                       vecs[i].s1low, vecs[i].s2low, int'(vecs[i].df) + 1, st);
            wait_frame($sformatf("v%0d frame", i), r);
            check($sformatf("v%0d dataout", i), 32'(r.data), 32'(vecs[i].exp_d));
            check($sformatf("v%0d parity_error", i), 32'(r.pe), 32'(vecs[i].exp_pe));
            check($sformatf("v%0d frame_error", i), 32'(r.fe), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d latency", i), 32'(r.c - st), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d single pulse", i), 32'(r.dbl), 32'h0);
            hold(4);
        end

        // Two-cycle glitch on an idle line is a false start
        cfg_df = CW'(9); cfg_db = 5'd8; cfg_par = 2'd0; cfg_stp = 2'd0;
        hold(5);
        uart_rxpin = 1'b0;
        hold(2);
        uart_rxpin = 1'b1;
        hold(2);
        check("glitch busy raised", 32'(rx_busy), 32'h1);
        hold(6);
        check("glitch busy cleared", 32'(rx_busy), 32'h0);
        hold(20);
        check("glitch no frame", 32'(rxq.size()), 32'h0);

        // Break: line held low ends in a framing error and no restart until high
        st = cyc;
        uart_rxpin = 1'b0;
        hold(120);
        wait_frame("break frame", r);
        check("break dataout", 32'(r.data), 32'h0);
        check("break frame_error", 32'(r.fe), 32'h1);
        check("break latency", 32'(r.c - st), 32'd98);
        hold(40);
        check("break stays idle", 32'(rx_busy), 32'h0);
        check("break no extra frame", 32'(rxq.size()), 32'h0);
        uart_rxpin = 1'b1;
        hold(20);
        check("break release no frame", 32'(rxq.size()), 32'h0);

        // Back-to-back 5-bit frames with 1.5 stop bits
        cfg_db = 5'd5; cfg_stp = 2'd1;
        hold(5);
        send_frame(8'h15, 5, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 10, st);
        send_frame(8'h0A, 5, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 10, dummy);
        wait_frame("b2b first", r);
        check("b2b first dataout", 32'(r.data), 32'h15);
        check("b2b first frame_error", 32'(r.fe), 32'h0);
        check("b2b first latency", 32'(r.c - st), 32'd68);
        wait_frame("b2b second", r);
        check("b2b second dataout", 32'(r.data), 32'h0A);
        check("b2b second frame_error", 32'(r.fe), 32'h0);

        // Reset in the middle of the data bits, then a clean frame
        cfg_db = 5'd8; cfg_stp = 2'd0;
        hold(5);
        fork
            send_frame(8'hC3, 8, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 10, dummy);
            begin
                hold(40);
                rst_n = 1'b0;
                hold(1);
                check("midreset dataout", 32'(dataout), 32'h0);
                check("midreset rx_valid", 32'(rx_valid), 32'h0);
                check("midreset parity_error", 32'(parity_error), 32'h0);
                check("midreset frame_error", 32'(frame_error), 32'h0);
                check("midreset rx_busy", 32'(rx_busy), 32'h0);
                rst_n = 1'b1;
            end
        join
        n = 0;
        while (rx_busy && n < 300) begin
            hold(1);
            n++;
        end
        check("midreset settles", 32'(rx_busy), 32'h0);
        hold(20);
        rxq.delete();
        send_frame(8'h5A, 8, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 10, st);
        wait_frame("post reset frame", r);
        check("post reset dataout", 32'(r.data), 32'h5A);
        check("post reset parity_error", 32'(r.pe), 32'h0);
        check("post reset frame_error", 32'(r.fe), 32'h0);
        check("post reset latency", 32'(r.c - st), 32'd98);

        hold(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
